// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants for the MIPS pipeline fetch path
package mips_pkg;

  // Next-PC source select codes (2'b11 is reserved and behaves as sequential)
  localparam logic [1:0]  PC_SEL_SEQ = 2'b00;
  localparam logic [1:0]  PC_SEL_NPC = 2'b01;
  localparam logic [1:0]  PC_SEL_REG = 2'b10;

  // Reset PC and instruction memory window
  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] IM_BASE    = 32'h0000_3000;
  localparam int          IM_WORDS   = 4096;

  // Encoding of the bubble placed in IF/ID by reset
  localparam logic [31:0] NOP        = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - stall-enabled IF/ID pipeline register
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_ir,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc4,
  output logic [31:0] o_ir,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4,
  output logic        o_valid
);

  logic [31:0] r_ir;
  logic [31:0] r_pc;
  logic [31:0] r_pc4;
  logic        r_valid;

  // Capture the fetched instruction when not stalled; reset inserts a nop bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir    <= NOP;
      r_pc    <= 32'h0;
      r_pc4   <= 32'h0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_ir    <= i_ir;
      r_pc    <= i_pc;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end
  end

  assign o_ir    = r_ir;
  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC register, next-PC mux, fetch range check
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = mips_pkg::PC_RESET,
  parameter logic [31:0] IM_BASE  = mips_pkg::IM_BASE,
  parameter int          IM_WORDS = mips_pkg::IM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] npc_in,
  input  logic [31:0] reg_target,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_f,
  output logic [31:0] ir_d,
  output logic [31:0] pc4_d,
  output logic [31:0] pc_d,
  output logic        valid_d,
  output logic        fetch_err
);

  // One past the last legal fetch address, widened so a window touching 2^32 cannot wrap
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic [31:0] r_pc;
  logic        r_err;
  logic [31:0] w_pc4;
  logic [31:0] w_next_pc;
  logic        w_err_now;

  assign w_pc4 = r_pc + 32'd4;

  // Next-PC select; the reserved code falls through to sequential fetch
  always_comb begin
    w_next_pc = w_pc4;
    case (pc_sel)
      PC_SEL_NPC: w_next_pc = npc_in;
      PC_SEL_REG: w_next_pc = reg_target;
      default:    w_next_pc = w_pc4;
    endcase
  end

  // Current fetch address is misaligned or outside the instruction memory window
  always_comb begin
    w_err_now = (r_pc[1:0] != 2'b00) ||
                (r_pc < IM_BASE) ||
                ({1'b0, r_pc} >= IM_LIMIT);
  end

  // PC advances and the sticky fetch error accumulates only on unstalled edges
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= PC_RESET;
      r_err <= 1'b0;
    end else if (!stall) begin
      r_pc <= w_next_pc;
      if (w_err_now) begin
        r_err <= 1'b1;
      end
    end
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .reset   (reset),
    .i_load  (!stall),
    .i_ir    (instr_in),
    .i_pc    (r_pc),
    .i_pc4   (w_pc4),
    .o_ir    (ir_d),
    .o_pc    (pc_d),
    .o_pc4   (pc4_d),
    .o_valid (valid_d)
  );

  assign pc_f      = r_pc;
  assign fetch_err = r_err;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam longint      WORDS = 4096;
  localparam logic [31:0] SALT  = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] pcd;
    logic [31:0] pc4;
    logic        v;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  pc_sel = 2'b00;
  logic [31:0] npc_in = 32'h0;
  logic [31:0] reg_target = 32'h0;
  logic [31:0] instr_in;
  logic [31:0] pc_f;
  logic [31:0] ir_d;
  logic [31:0] pc4_d;
  logic [31:0] pc_d;
  logic        valid_d;
  logic        fetch_err;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb[$];

  logic [31:0] m_pc, m_ir, m_pcd, m_pc4;
  logic        m_v, m_err;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .pc_sel     (pc_sel),
    .npc_in     (npc_in),
    .reg_target (reg_target),
    .instr_in   (instr_in),
    .pc_f       (pc_f),
    .ir_d       (ir_d),
    .pc4_d      (pc4_d),
    .pc_d       (pc_d),
    .valid_d    (valid_d),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  // Combinational instruction ROM: each word is tagged with its own address
  assign instr_in = pc_f ^ SALT;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ SALT;
  endfunction

  function automatic bit legal(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la % 4 == 0) && (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * WORDS);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and record what the architecture must look like after the edge
  task automatic cycle(input bit rst, input bit st, input logic [1:0] sel,
                       input logic [31:0] npc, input logic [31:0] rt);
    exp_t e;
    @(negedge clk);
    reset = rst; stall = st; pc_sel = sel; npc_in = npc; reg_target = rt;
    if (rst) begin
      m_pc = BASE; m_ir = 32'h0; m_pcd = 32'h0; m_pc4 = 32'h0; m_v = 1'b0; m_err = 1'b0;
    end else if (!st) begin
      if (!legal(m_pc)) m_err = 1'b1;
      m_ir  = rom(m_pc);
      m_pcd = m_pc;
      m_pc4 = m_pc + 32'd4;
      m_v   = 1'b1;
      if (sel == 2'b01)      m_pc = npc;
      else if (sel == 2'b10) m_pc = rt;
      else                   m_pc = m_pc + 32'd4;
    end
    e.pc = m_pc; e.ir = m_ir; e.pcd = m_pcd; e.pc4 = m_pc4; e.v = m_v; e.err = m_err;
    sb.push_back(e);
  endtask

  // Monitor: after every edge, compare DUT state with the oldest outstanding expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_pc_f",      pc_f,             e.pc);
      chk("sb_ir_d",      ir_d,             e.ir);
      chk("sb_pc_d",      pc_d,             e.pcd);
      chk("sb_pc4_d",     pc4_d,            e.pc4);
      chk("sb_valid_d",   {31'h0, valid_d}, {31'h0, e.v});
      chk("sb_fetch_err", {31'h0, fetch_err}, {31'h0, e.err});
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last_word;
    last_word = BASE + 32'(4 * WORDS) - 32'd4;

    // Reset, then sequential fetch
    cycle(1, 0, 2'b00, 32'h0, 32'h0);
    cycle(1, 0, 2'b00, 32'h0, 32'h0);
    cycle(0, 0, 2'b00, 32'h0, 32'h0);
    chk("rst_pc_f", pc_f, 32'h3000);
    chk("rst_ir_d", ir_d, 32'h0);
    chk("rst_valid", {31'h0, valid_d}, 32'h0);
    chk("rst_err", {31'h0, fetch_err}, 32'h0);
    cycle(0, 0, 2'b00, 32'h0, 32'h0);
    chk("seq_pc_3004", pc_f, 32'h3004);
    chk("seq_ir_3000", ir_d, 32'h3000 ^ SALT);
    chk("seq_valid", {31'h0, valid_d}, 32'h1);

    // Redirect via npc at 3008; 3008 itself is the delay slot and still enters IF/ID
    cycle(0, 0, 2'b01, 32'h3040, 32'h0);
    chk("br_pc_3008", pc_f, 32'h3008);
    cycle(0, 0, 2'b00, 32'h0, 32'h0);
    chk("br_pc_3040", pc_f, 32'h3040);
    chk("br_slot_ir", ir_d, 32'h3008 ^ SALT);
    chk("br_slot_pc4", pc4_d, 32'h300C);
    cycle(0, 0, 2'b00, 32'h0, 32'h0);
    chk("br_tgt_ir", ir_d, 32'h3040 ^ SALT);

    // Register redirect held off by two stalled edges
    cycle(0, 1, 2'b10, 32'h0, 32'h3100);
    chk("st_pc_before", pc_f, 32'h3048);
    cycle(0, 1, 2'b10, 32'h0, 32'h3100);
    chk("st_pc_hold1", pc_f, 32'h3048);
    chk("st_ir_hold1", ir_d, 32'h3044 ^ SALT);
    cycle(0, 0, 2'b10, 32'h0, 32'h3100);
    chk("st_pc_hold2", pc_f, 32'h3048);
    chk("st_pcd_hold2", pc_d, 32'h3044);

    // Misaligned register target sets the sticky error
    cycle(0, 0, 2'b10, 32'h0, 32'h3102);
    chk("jr_pc_3100", pc_f, 32'h3100);
    cycle(0, 0, 2'b00, 32'h0, 32'h0);
    chk("mis_pc", pc_f, 32'h3102);
    chk("mis_err_pre", {31'h0, fetch_err}, 32'h0);
    cycle(0, 0, 2'b00, 32'h0, 32'h0);
    chk("mis_err_set", {31'h0, fetch_err}, 32'h1);
    cycle(0, 0, 2'b01, 32'h3000, 32'h0);
    cycle(0, 0, 2'b00, 32'h0, 32'h0);
    chk("mis_err_sticky", {31'h0, fetch_err}, 32'h1);

    // Last legal word, then sequential fetch falls off the end
    cycle(1, 0, 2'b00, 32'h0, 32'h0);
    cycle(0, 0, 2'b01, last_word, 32'h0);
    cycle(0, 0, 2'b11, 32'h0, 32'h0);
    chk("end_pc_last", pc_f, last_word);
    cycle(0, 0, 2'b00, 32'h0, 32'h0);
    chk("end_pc_out", pc_f, last_word + 32'd4);
    chk("end_err_pre", {31'h0, fetch_err}, 32'h0);
    cycle(0, 0, 2'b01, 32'h3020, 32'h0);
    chk("end_err_set", {31'h0, fetch_err}, 32'h1);

    // Reset during a stall with a pending redirect
    cycle(0, 1, 2'b01, 32'h3300, 32'h0);
    chk("rs_pc_3020", pc_f, 32'h3020);
    cycle(1, 1, 2'b10, 32'h3300, 32'h3400);
    cycle(0, 1, 2'b00, 32'h0, 32'h0);
    chk("rs_pc", pc_f, 32'h3000);
    chk("rs_valid", {31'h0, valid_d}, 32'h0);
    chk("rs_ir", ir_d, 32'h0);
    chk("rs_err", {31'h0, fetch_err}, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit          rst, st;
      logic [1:0]  sel;
      logic [31:0] npc, rt;
      rst = ($urandom_range(0, 49) == 0);
      st  = ($urandom_range(0, 3) == 0);
      sel = 2'($urandom_range(0, 3));
      npc = ($urandom_range(0, 9) == 0) ? 32'($urandom) : BASE + (32'($urandom_range(0, 4095)) << 2);
      rt  = ($urandom_range(0, 9) == 0) ? 32'($urandom) : BASE + (32'($urandom_range(0, 4095)) << 2);
      cycle(rst, st, sel, npc, rt);
    end

    @(posedge clk);
    #2;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline: holds the architectural PC and drives the instruction-memory address.
- Selects the next PC from sequential PC+4, the D-stage next-PC unit's branch/jump target, or a register target (jr/jalr).
- Owns the IF/ID pipeline register (IR_D, PC4_D, valid_D) consumed by decode and by the next-PC unit.
- Branch delay slot architecture: no flush path; the delay-slot instruction always proceeds.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_WORDS, 4096, instruction memory depth in words; legal range is [IM_BASE, IM_BASE+4*IM_WORDS).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; freezes PC and IF/ID.
- pc_sel  in  2  00 = PC+4, 01 = npc_in, 10 = reg_target, 11 = reserved (treated as 00).
- npc_in  in  32  target from the D-stage next-PC unit.
- reg_target  in  32  forwarded rs value for jr/jalr.
- instr_in  in  32  instruction-memory read data for pc_f (combinational ROM).
- pc_f  out  32  current fetch address to instruction memory.
- ir_d  out  32  IF/ID instruction.
- pc4_d  out  32  IF/ID PC+4 of that instruction.
- pc_d  out  32  IF/ID PC of that instruction.
- valid_d  out  1  IF/ID contents are a real fetched instruction.
- fetch_err  out  1  sticky: a misaligned or out-of-range pc_f was presented while not stalled.

Behaviour:
- Reset (synchronous, checked on the clk edge, overrides everything):
  - pc_f = PC_RESET.
  - ir_d = 0 (nop), pc4_d = 0, pc_d = 0.
  - valid_d = 0, fetch_err = 0.
- Next-PC mux (combinational): next_pc = pc_sel==01 ? npc_in : pc_sel==10 ? reg_target : pc_f+4. The +4 is modulo 2^32; wrap-around is allowed but flagged by the range check.
- Each rising edge with stall=0:
  - pc_f <= next_pc.
  - ir_d <= instr_in, pc_d <= pc_f, pc4_d <= pc_f+4.
  - valid_d <= 1.
- Rising edge with stall=1: pc_f, ir_d, pc_d, pc4_d and valid_d all hold. pc_sel, npc_in and reg_target are ignored that cycle; the hazard unit re-presents them.
- Latency:
  - An instruction at address A is visible on ir_d one cycle after pc_f==A (unstalled).
  - A redirect asserted in cycle t appears on pc_f in cycle t+1.
  - The instruction in IF during cycle t is the delay slot and still enters IF/ID.
- Range check: err_now = pc_f[1:0]!=0, or pc_f<IM_BASE, or pc_f>=IM_BASE+4*IM_WORDS.
- fetch_err: set on an edge where stall=0 and err_now=1; cleared only by reset. The instruction is still latched (no trap in this stage).
- Simultaneous stall and redirect: stall wins; the redirect is lost unless re-presented.
- pc_sel=11: behaves exactly as 00.
- No combinational path from any input to pc_f, ir_d, pc_d, pc4_d, valid_d or fetch_err.

Decomposition:
- Shared package mips_pkg: PC_SEL_SEQ=2'b00, PC_SEL_NPC=2'b01, PC_SEL_REG=2'b10; PC_RESET; IM_BASE; NOP=32'h0.
- One sub-module, if_id_reg: a stall-enabled register for ir_d, pc_d, pc4_d and valid_d.
- The PC register, next-PC mux and range check stay in fetch_stage.

Test Plan:
- Reset then 4 unstalled cycles, pc_sel=00, instr_in=pc_f ^ 32'hA5A5_0000:
  - pc_f = 3000, 3004, 3008, 300C.
  - ir_d lags pc_f by one cycle; pc4_d = pc_d+4; valid_d rises on the first edge.
- At pc_f=3008, pc_sel=01, npc_in=3040 for one cycle:
  - next pc_f = 3040.
  - ir_d = the 3008 instruction, then the 3040 instruction; no flush.
- pc_sel=10, reg_target=3100 with stall=1 for 2 cycles, then stall=0:
  - pc_f and IF/ID hold both stalled cycles.
  - Redirect takes effect only on the unstalled edge.
- reg_target=3102 redirect: fetch_err=1 the cycle after pc_f=3102 is fetched; stays 1 until reset.
- pc_f=3000+4*IM_WORDS-4 with pc_sel=00: next pc_f is out of range, and fetch_err sets one edge later.
- Reset asserted mid-stall with pc_f=3020: next edge gives pc_f=3000, valid_d=0, ir_d=0, fetch_err=0, regardless of stall and pc_sel.
